// File: rtl/cp0_irq_pkg.sv
// Shared CP0 interrupt-controller constants: register map, STATUS/CAUSE field
// positions and the handler-vector stride.
package cp0_irq_pkg;

    typedef enum logic [1:0] {
        CP0_STATUS = 2'd0,
        CP0_CAUSE  = 2'd1,
        CP0_EPC    = 2'd2,
        CP0_RSVD   = 2'd3
    } cp0_addr_e;

    localparam int STATUS_IE_BIT   = 0;
    localparam int STATUS_MASK_LSB = 1;
    localparam int CAUSE_IDX_LSB   = 27;
    localparam int IDX_W           = 5;
    localparam int VEC_SHIFT       = 3;

endpackage

// File: rtl/cp0_irq_ctrl_if.sv
// Bundle of the CPU <-> CP0 exception/register-access signals.
// The master modport is the pipeline side, the slave modport is the CP0 side.
interface cp0_irq_ctrl_if #(
    parameter int NUM_SRC = 3,
    parameter int PC_W    = 32
);
    logic [NUM_SRC-1:0] exp_src;
    logic [PC_W-1:0]    pc_in;
    logic               instr_done;
    logic               eret;
    logic               mtc0_we;
    logic [1:0]         mtc0_addr;
    logic [31:0]        mtc0_data;
    logic [1:0]         mfc0_addr;
    logic [31:0]        mfc0_data;
    logic               exp_take;
    logic [PC_W-1:0]    exp_vec;
    logic               eret_take;
    logic [PC_W-1:0]    epc;
    logic               in_handler;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output exp_src, pc_in, instr_done, eret, mtc0_we, mtc0_addr, mtc0_data, mfc0_addr,
        input  mfc0_data, exp_take, exp_vec, eret_take, epc, in_handler, pending
    );

    modport slave (
        input  exp_src, pc_in, instr_done, eret, mtc0_we, mtc0_addr, mtc0_data, mfc0_addr,
        output mfc0_data, exp_take, exp_vec, eret_take, epc, in_handler, pending
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest asserted request index wins (index 0 highest).
// Purely combinational.
module irq_prio_enc
    import cp0_irq_pkg::*;
#(
    parameter int NUM_SRC = 3
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downwards so the last hit is the lowest index.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 exception controller: edge-latched requests, STATUS/CAUSE/EPC registers, EPC stack.
// NESTED_EXP_EN enables preemption by higher-priority sources with a NEST_DEPTH-deep stack.
module cp0_irq_ctrl
    import cp0_irq_pkg::*;
#(
    parameter int          NUM_SRC    = 3,
    parameter int          PC_W       = 32,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter int          NEST_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] exp_src,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               instr_done,
    input  logic               eret,
    input  logic               mtc0_we,
    input  logic [1:0]         mtc0_addr,
    input  logic [31:0]        mtc0_data,
    input  logic [1:0]         mfc0_addr,
    output logic [31:0]        mfc0_data,
    output logic               exp_take,
    output logic [PC_W-1:0]    exp_vec,
    output logic               eret_take,
    output logic [PC_W-1:0]    epc,
    output logic               in_handler,
    output logic [NUM_SRC-1:0] pending
);

`ifdef NESTED_EXP_EN
    localparam int STK_D = NEST_DEPTH;
`else
    localparam int STK_D = 1;
`endif
    localparam int SP_W  = $clog2(STK_D + 1);
    localparam int PTR_W = (STK_D > 1) ? $clog2(STK_D) : 1;

    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC:0]   status_q, status_d;
    logic [PC_W-1:0]    epc_stk_q [STK_D];
    logic [PC_W-1:0]    epc_stk_d [STK_D];
    logic [IDX_W-1:0]   idx_stk_q [STK_D];
    logic [IDX_W-1:0]   idx_stk_d [STK_D];
    logic [SP_W-1:0]    sp_q, sp_d;

    logic               ie;
    logic [NUM_SRC-1:0] enabled;
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   top_ptr;
    logic [PTR_W-1:0]   push_ptr;
    logic [IDX_W-1:0]   act_idx;
    logic               take_allowed;
    logic [NUM_SRC-1:0] clr;

    assign ie      = status_q[STATUS_IE_BIT];
    assign enabled = pend_q & status_q[NUM_SRC:STATUS_MASK_LSB];

    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .req   (enabled),
        .valid (sel_vld),
        .idx   (sel_idx)
    );

    // With an empty stack the top pointer rests on entry 0, so EPC and the
    // active index keep showing the last handler's values after it returns.
    assign in_handler = (sp_q != '0);
    assign top_ptr    = in_handler ? PTR_W'(sp_q - SP_W'(1)) : '0;
    assign push_ptr   = PTR_W'(sp_q);
    assign act_idx    = idx_stk_q[top_ptr];
    assign epc        = epc_stk_q[top_ptr];
    assign pending    = pend_q;

`ifdef NESTED_EXP_EN
    assign take_allowed = ~in_handler | ((sp_q < SP_W'(STK_D)) & (sel_idx < act_idx));
`else
    assign take_allowed = ~in_handler;
`endif

    // eret outranks a coincident take; the request stays pending for a later retire.
    assign eret_take = eret & in_handler;
    assign exp_take  = instr_done & ie & sel_vld & take_allowed & ~eret_take;
    assign exp_vec   = PC_W'(VEC_BASE) + (PC_W'(sel_idx) << VEC_SHIFT);

    always_comb begin
        mfc0_data = '0;
        case (cp0_addr_e'(mfc0_addr))
            CP0_STATUS: mfc0_data = 32'(status_q);
            CP0_CAUSE: begin
                mfc0_data[NUM_SRC-1:0]                = pend_q;
                mfc0_data[CAUSE_IDX_LSB +: IDX_W]     = act_idx;
            end
            CP0_EPC:    mfc0_data = 32'(epc);
            default:    mfc0_data = '0;
        endcase
    end

    always_comb begin
        prev_d    = exp_src;
        clr       = exp_take ? (NUM_SRC'(1) << sel_idx) : '0;
        // A fresh edge on the source being cleared keeps it pending.
        pend_d    = (pend_q & ~clr) | (exp_src & ~prev_q);
        status_d  = status_q;
        epc_stk_d = epc_stk_q;
        idx_stk_d = idx_stk_q;
        sp_d      = sp_q;

        if (mtc0_we && cp0_addr_e'(mtc0_addr) == CP0_STATUS)
            status_d = mtc0_data[NUM_SRC:0];
        if (mtc0_we && cp0_addr_e'(mtc0_addr) == CP0_EPC)
            epc_stk_d[top_ptr] = PC_W'(mtc0_data);

        if (exp_take) begin
            epc_stk_d[push_ptr] = pc_in + PC_W'(4);
            idx_stk_d[push_ptr] = sel_idx;
            sp_d                = sp_q + SP_W'(1);
        end else if (eret_take) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= '0;
            pend_q   <= '0;
            status_q <= '0;
            sp_q     <= '0;
            for (int i = 0; i < STK_D; i++) begin
                epc_stk_q[i] <= '0;
                idx_stk_q[i] <= '0;
            end
        end else begin
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            status_q  <= status_d;
            sp_q      <= sp_d;
            epc_stk_q <= epc_stk_d;
            idx_stk_q <= idx_stk_d;
        end
    end

endmodule

// File: doc/cp0_irq_ctrl.md
CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: number of exception sources, legal range 1..27.
REQ-002 SHALL have parameter PC_W, default 32: PC width.
REQ-003 SHALL have parameter VEC_BASE, default 32'h0000_0800: handler base address.
REQ-004 SHALL have parameter NEST_DEPTH, default 4: EPC stack depth; used only with NESTED_EXP_EN.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- exp_src  in  NUM_SRC  exception request lines.
- pc_in  in  PC_W  PC of the retiring instruction.
- instr_done  in  1  instruction retires this cycle.
- eret  in  1  eret decoded this cycle.
- mtc0_we  in  1  register write strobe.
- mtc0_addr  in  2  write address.
- mtc0_data  in  32  write data.
- mfc0_addr  in  2  read address.
- mfc0_data  out  32  read data.
- exp_take  out  1  redirect PC to exp_vec.
- exp_vec  out  PC_W  handler address.
- eret_take  out  1  redirect PC to epc.
- epc  out  PC_W  return address (top of stack).
- in_handler  out  1  a handler is active.
- pending  out  NUM_SRC  latched requests.

Function
REQ-006 SHALL latch requests on rising edges only: at each clk edge prev<=exp_src and pending|=exp_src&~prev; pending is visible the cycle after the edge.
REQ-007 SHALL make the STATUS register (addr 0) bit0 = IE and bits[NUM_SRC:1] = per-source mask; bit=1 enables the source.
REQ-008 SHALL make the CAUSE register (addr 1) bits[NUM_SRC-1:0] = pending and bits[31:27] = active source index; addr 2 = epc zero-extended; addr 3 reads 0 and ignores writes.
REQ-009 SHALL drive mfc0_data combinationally from mfc0_addr; writes to CAUSE/EPC SHALL affect only the EPC top entry (addr 2); CAUSE is read-only.
REQ-010 SHALL drive exp_take combinationally as instr_done & IE & |(pending&mask) & take_allowed; take_allowed = ~in_handler when nesting is compiled out.
REQ-011 SHALL select the lowest asserted index of pending&mask (index 0 = highest priority) and set exp_vec = VEC_BASE + (idx<<3).
REQ-012 SHALL, at the edge ending an exp_take cycle, push epc<=pc_in+4 and the active index, clear that pending bit, and set in_handler.
REQ-013 SHALL assert eret_take = eret & in_handler; at that edge it pops the stack, and in_handler falls when the stack empties. eret with ~in_handler SHALL be ignored.
REQ-014 SHALL give eret precedence when eret and exp_take conditions coincide; the pending exception SHALL be taken at a later instr_done (tail-chaining).
REQ-015 SHALL let a new edge win over the clear when it arrives on the same source being cleared; pending stays 1.
REQ-016 SHALL evaluate a take using the pre-write STATUS when an mtc0 write coincides with it; the write takes effect at the same edge.
REQ-017 SHALL produce no exp_take without instr_done; requests stay pending indefinitely.

Reset
REQ-018 SHALL, on reset, clear prev, pending, STATUS, the stack, and in_handler; all outputs read 0 except exp_vec=VEC_BASE. Reset mid-handler abandons the handler.
REQ-019 SHALL treat a source held high through reset release as a new edge and pend it one cycle later.

Configuration
REQ-020 SHALL support macro NESTED_EXP_EN:
- Defined: take_allowed = ~in_handler | (stack not full & new idx < active idx); a NEST_DEPTH-entry EPC/index stack is used.
- Undefined: single level, stack depth 1, NEST_DEPTH ignored.

Structure
REQ-021 SHALL place the register addresses, STATUS/CAUSE bit positions, and the VEC shift constant in package cp0_irq_pkg.
REQ-022 SHALL implement priority selection in sub-module irq_prio_enc (parameter NUM_SRC; outputs valid and idx).

Verification
REQ-023 SHALL cover these directed scenarios:
- STATUS=0x3, pulse exp_src[0], instr_done with pc_in=0x100 -> exp_take=1, exp_vec=0x800, next cycle epc=0x104, CAUSE[31:27]=0.
- exp_src=3'b110 edges together, mask all -> source 1 taken first (vec 0x808); after eret, source 2 taken (vec 0x810).
- In handler for source 2, source 0 edge -> with NESTED_EXP_EN, preempts and a two-level eret returns through both EPCs; without it, source 0 waits until eret.
- IE=0 with pending=001 -> no exp_take; mtc0 STATUS=0x3 -> taken at the next instr_done.
- eret and take conditions coincide -> eret_take=1, exp_take=0; reset asserted in handler -> in_handler=0, pending=0 next cycle.
